// File: rtl/seq_binary_divider.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock.
// Optional SEQ_DIV_ZERO_DETECT_EN: divide-by-zero finishes at the capture edge with err=1.
module seq_binary_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] part;
  logic [WIDTH:0]   step;
  logic             accept;
  logic             last;
  logic             zero_div;

  // Returns {quotient bit, new partial remainder}. The restored or reduced
  // partial always fits in WIDTH bits, so its top bit is never stored.
  function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] rem,
                                               input logic             msb,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem, msb};
    trial   = shifted - {1'b0, d};
    if (!trial[WIDTH])
      return {1'b1, trial[WIDTH-1:0]};
    return {1'b0, shifted[WIDTH-1:0]};
  endfunction

`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign zero_div = (b == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign step   = div_step(part, dvd[WIDTH-1], dvs);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DONE : RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = zero_div ? DONE : RUN;
               else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= '0;
      r   <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (zero_div) begin
        q <= '1;
        r <= a;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        q <= {dvd[WIDTH-2:0], step[WIDTH]};
        r <= step[WIDTH-1:0];
      end
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (accept)
      err <= zero_div;
  end
`else
  assign err = 1'b0;
`endif

  // Iteration datapath: quotient bits fill the dividend register from the LSB
  // as the dividend bits are shifted out of the MSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd  <= a;
      dvs  <= b;
      part <= '0;
    end else if (state == RUN) begin
      dvd  <= {dvd[WIDTH-2:0], step[WIDTH]};
      part <= step[WIDTH-1:0];
    end
  end

endmodule
